spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Byte-level command parser between the SPI slave (MySpi) and the 7-segment driver (WF_BL_7seg_if).
- Consumes received SPI bytes, updates the four BCD digit registers and the colon register, and loads a response byte for the next SPI transfer.
- Replaces the fixed 0xA5 reply with a protocol that carries status and readback.

Parameters:
- TIMEOUT_CYCLES, 1600000, WF_CLK cycles allowed between an opcode and each of its argument bytes (about 100 ms at 16 MHz).
- ACK_BYTE, 8'hA5, response byte for an accepted opcode or argument.
- NAK_BYTE, 8'hEE, response byte for an unknown opcode, a bad argument or a timeout.

Ports:
- WF_CLK  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse in the WF_CLK domain: rx_data is valid.
- rx_data  in  8  received SPI byte.
- tx_ready  out  1  one-cycle pulse: tx_data is loaded for the next SPI transfer.
- tx_data  out  8  response byte.
- digit0  out  4  BCD digit, least significant digit.
- digit1  out  4  BCD digit.
- digit2  out  4  BCD digit.
- digit3  out  4  BCD digit, most significant digit.
- colon  out  2  00 colon, 01 decimal point, 11 none.
- err_flag  out  1  sticky error flag.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Clocking and reset:
  - One clock (WF_CLK). Reset is asynchronous and active-high.
  - Reset values: digits 0, colon 2'b11, tx_data 8'h00, tx_ready 0, err_flag 0, busy 0, state IDLE, timeout counter 0.
- States: IDLE, ARG_DIGIT, ARG_COLON, ARG_ALL_HI, ARG_ALL_LO, READ_LO.
- Opcodes accepted in IDLE:
  - 0x10|n (n = 0..3): remember n, go to ARG_DIGIT. The next byte's [3:0] is written to digit n.
  - 0x20: go to ARG_COLON. The next byte's [1:0] is written to colon.
  - 0x30: go to ARG_ALL_HI. The next byte is {digit3, digit2}; then ARG_ALL_LO takes {digit1, digit0}. Both bytes are staged and committed together on the second byte, so the digits never show half of an update.
  - 0x40: tx_data <= {digit3, digit2}, go to READ_LO. The next byte (any value, ignored) loads tx_data <= {digit1, digit0} and returns to IDLE.
  - 0x50: clear err_flag, reply ACK, stay in IDLE.
  - Any other value: set err_flag, reply NAK_BYTE, stay in IDLE.
- Argument checks:
  - A nibble greater than 9 rejects the whole command: err_flag set, NAK, registers unchanged, return to IDLE.
  - For 0x30, if either byte has a bad nibble, neither byte is committed.
  - A valid argument replies ACK_BYTE.
- Response timing:
  - Every rx_valid produces exactly one tx_ready pulse on the next WF_CLK edge.
  - tx_data is stable from that edge until the next load.
  - Register updates happen on the same edge as the tx_ready pulse.
- Timeout:
  - The counter clears on every rx_valid and counts only in the ARG_* and READ_LO states.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, set err_flag, discard staged data. No tx_ready pulse.
  - If rx_valid arrives on the same cycle as the expiry, the byte wins and is processed in the current state.
- Boundaries:
  - rx_valid on consecutive cycles: each byte is processed and no byte is dropped.
  - tx_ready stays a single-cycle pulse per byte.
  - Reset mid-command: the command is aborted and all outputs take their reset values immediately.

Optional Feature:
- Macro: SPI_CMD_HEX_EN.
- Defined: digit nibbles 0xA–0xF are accepted (hex display), and the >9 check is removed.
- Undefined: strict BCD checking as described in Behaviour.

Decomposition:
- Package pifan_cmd_pkg:
  - opcode constants OP_DIGIT, OP_COLON, OP_ALL, OP_READ, OP_CLRERR;
  - state enum;
  - colon encodings COLON_ON, COLON_DP, COLON_OFF;
  - default ACK and NAK values.
- One sub-module, cmd_timeout_counter, with ports clear, enable and expired.
  - Parameterised width of $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset released -> digits 0, colon 11, err 0, tx_ready low. Reset asserted mid-command after 0x30 -> state IDLE, digits unchanged at 0.
- Bytes 0x12, 0x07 -> digit2 = 7, two tx_ready pulses, each one cycle after its rx_valid, tx_data A5 both times.
- Bytes 0x30, 0x12, 0x34 -> after the second byte digits 3..0 = 1,2,3,4 update on the same edge. Bytes 0x30, 0x1A, 0x34 -> NAK, err = 1, digits unchanged (strict BCD build).
- With digits 1234, bytes 0x40, 0x00 -> tx_data 0x12 then 0x34.
- Byte 0x10, then no byte for TIMEOUT_CYCLES (reduced to 20 for simulation) -> IDLE, err = 1, busy = 0, no tx_ready. A byte arriving exactly on the expiry cycle is applied to the digit.
- Byte 0x99 -> NAK, err = 1. Byte 0x50 -> ACK, err = 0. Back-to-back rx_valid of 0x20 and 0x01 -> colon = 01.

Source files
------------

// File: rtl/pifan_cmd_pkg.sv
// Shared opcodes, FSM states and reply bytes for the SPI command decoder.
// Define SPI_CMD_HEX_EN to accept hex digit nibbles (A-F) instead of strict BCD.
package pifan_cmd_pkg;

    localparam logic [7:0] OP_DIGIT    = 8'h10;
    localparam logic [7:0] OP_COLON    = 8'h20;
    localparam logic [7:0] OP_ALL      = 8'h30;
    localparam logic [7:0] OP_READ     = 8'h40;
    localparam logic [7:0] OP_CLRERR   = 8'h50;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;

    localparam logic [1:0] COLON_ON    = 2'b00;
    localparam logic [1:0] COLON_DP    = 2'b01;
    localparam logic [1:0] COLON_OFF   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARG_DIGIT = 3'd1,
        ST_ARG_COLON = 3'd2,
        ST_ARG_ALL_HI = 3'd3,
        ST_ARG_ALL_LO = 3'd4,
        ST_READ_LO   = 3'd5
    } state_e;

    function automatic logic nibble_ok(input logic [3:0] nib);
`ifdef SPI_CMD_HEX_EN
        nibble_ok = (nib <= 4'hF);
`else
        nibble_ok = (nib <= 4'd9);
`endif
    endfunction

    function automatic logic byte_ok(input logic [7:0] b);
        byte_ok = nibble_ok(b[7:4]) & nibble_ok(b[3:0]);
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte watchdog: counts while enabled, flags expiry on the last count,
// and restarts from zero whenever cleared or disabled.
module cmd_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1600000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at LAST so a held expiry never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/spi_cmd_decoder.sv
// Byte-level command parser driving the four BCD digits and colon of the display,
// with one ACK/NAK/readback reply per received byte.
module spi_cmd_decoder
    import pifan_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1600000,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
    input  logic       WF_CLK,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       err_flag,
    output logic       busy
);
    state_e          state_q, state_d;
    logic [3:0][3:0] digits_q, digits_d;
    logic [1:0]      colon_q, colon_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_ready_q, tx_ready_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      stage_q, stage_d;
    logic            expired_s;

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (WF_CLK),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (state_q != ST_IDLE),
        .expired(expired_s)
    );

    // Command decode: a received byte always wins over a simultaneous timeout.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        colon_d    = colon_q;
        tx_data_d  = tx_data_q;
        tx_ready_d = 1'b0;
        err_d      = err_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        if (rx_valid) begin
            tx_ready_d = 1'b1;
            tx_data_d  = ACK_BYTE;
            state_d    = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data[7:2] == OP_DIGIT[7:2]) begin
                        idx_d   = rx_data[1:0];
                        state_d = ST_ARG_DIGIT;
                    end else begin
                        case (rx_data)
                            OP_COLON:  state_d = ST_ARG_COLON;
                            OP_ALL:    state_d = ST_ARG_ALL_HI;
                            OP_READ: begin
                                tx_data_d = {digits_q[3], digits_q[2]};
                                state_d   = ST_READ_LO;
                            end
                            OP_CLRERR: err_d = 1'b0;
                            default: begin
                                err_d     = 1'b1;
                                tx_data_d = NAK_BYTE;
                            end
                        endcase
                    end
                end
                ST_ARG_DIGIT: begin
                    if (nibble_ok(rx_data[3:0])) begin
                        digits_d[idx_q] = rx_data[3:0];
                    end else begin
                        err_d     = 1'b1;
                        tx_data_d = NAK_BYTE;
                    end
                end
                ST_ARG_COLON: colon_d = rx_data[1:0];
                ST_ARG_ALL_HI: begin
                    if (byte_ok(rx_data)) begin
                        stage_d = rx_data;
                        state_d = ST_ARG_ALL_LO;
                    end else begin
                        err_d     = 1'b1;
                        tx_data_d = NAK_BYTE;
                    end
                end
                ST_ARG_ALL_LO: begin
                    // Both halves land together so the display never shows a torn value.
                    if (byte_ok(rx_data)) begin
                        digits_d = {stage_q, rx_data};
                    end else begin
                        err_d     = 1'b1;
                        tx_data_d = NAK_BYTE;
                    end
                    stage_d = 8'h00;
                end
                ST_READ_LO: tx_data_d = {digits_q[1], digits_q[0]};
                default: begin
                    err_d     = 1'b1;
                    tx_data_d = NAK_BYTE;
                end
            endcase
        end else if (expired_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            stage_d = 8'h00;
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            colon_q    <= COLON_OFF;
            tx_data_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            idx_q      <= 2'd0;
            stage_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            colon_q    <= colon_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx_data  = tx_data_q;
    assign digit0   = digits_q[0];
    assign digit1   = digits_q[1];
    assign digit2   = digits_q[2];
    assign digit3   = digits_q[3];
    assign colon    = colon_q;
    assign err_flag = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (strict BCD build, timeout of 20 cycles).
module tb_spi_cmd_decoder;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       err_flag;
    logic       busy;

    int pass_cnt;
    int total_cnt;

    spi_cmd_decoder #(
        .TIMEOUT_CYCLES(20)
    ) dut (
        .WF_CLK  (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .digit0  (digit0),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .colon   (colon),
        .err_flag(err_flag),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte for one cycle; sample the reply at the falling edge after the capture edge.
    task automatic send(input logic [7:0] b, output logic rdy, output logic [7:0] data);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rdy      = tx_ready;
        data     = tx_data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0000)
            $display("FAIL reset_digits got %h want 0000", {digit3, digit2, digit1, digit0});
        else pass_cnt++;
        total_cnt++;
        if (colon !== 2'b11) $display("FAIL reset_colon got %b want 11", colon);
        else pass_cnt++;
        total_cnt++;
        if ({err_flag, tx_ready, busy} !== 3'b000)
            $display("FAIL reset_flags got err=%b rdy=%b busy=%b want 000", err_flag, tx_ready, busy);
        else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h00) $display("FAIL reset_txdata got %h want 00", tx_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic r; logic [7:0] d;
        send(8'h30, r, d);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, tx_ready, tx_data} !== 10'h000)
            $display("FAIL mid_reset_async got busy=%b rdy=%b tx=%h want 0 0 00", busy, tx_ready, tx_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        // 0x34 is an unknown opcode in IDLE; a stale ALL_HI would ACK it instead.
        send(8'h34, r, d);
        total_cnt++;
        if ({r, d, err_flag, digit3, digit2, digit1, digit0} !== {1'b1, 8'hEE, 1'b1, 16'h0000})
            $display("FAIL mid_after got rdy=%b tx=%h err=%b dig=%h want 1 EE 1 0000",
                     r, d, err_flag, {digit3, digit2, digit1, digit0});
        else pass_cnt++;
        send(8'h50, r, d);
    endtask

    task automatic test_digit;
        logic r; logic [7:0] d;
        send(8'h12, r, d);
        total_cnt++;
        if ({r, d, busy} !== {1'b1, 8'hA5, 1'b1})
            $display("FAIL digit_op got rdy=%b tx=%h busy=%b want 1 A5 1", r, d, busy);
        else pass_cnt++;
        send(8'h07, r, d);
        total_cnt++;
        if ({r, d, busy} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL digit_arg got rdy=%b tx=%h busy=%b want 1 A5 0", r, d, busy);
        else pass_cnt++;
        total_cnt++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0700)
            $display("FAIL digit_value got %h want 0700", {digit3, digit2, digit1, digit0});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (tx_ready !== 1'b0) $display("FAIL digit_pulse_width got %b want 0", tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_all;
        logic r; logic [7:0] d;
        send(8'h30, r, d);
        send(8'h12, r, d);
        total_cnt++;
        if ({d, digit3, digit2, digit1, digit0} !== {8'hA5, 16'h0700})
            $display("FAIL all_staged got tx=%h dig=%h want A5 0700", d, {digit3, digit2, digit1, digit0});
        else pass_cnt++;
        send(8'h34, r, d);
        total_cnt++;
        if ({r, d, digit3, digit2, digit1, digit0} !== {1'b1, 8'hA5, 16'h1234})
            $display("FAIL all_commit got rdy=%b tx=%h dig=%h want 1 A5 1234",
                     r, d, {digit3, digit2, digit1, digit0});
        else pass_cnt++;
    endtask

    task automatic test_all_bad;
        logic r; logic [7:0] d;
        send(8'h30, r, d);
        send(8'h1A, r, d);
        total_cnt++;
        if ({d, err_flag, busy} !== {8'hEE, 1'b1, 1'b0})
            $display("FAIL all_bad_hi got tx=%h err=%b busy=%b want EE 1 0", d, err_flag, busy);
        else pass_cnt++;
        send(8'h34, r, d);
        total_cnt++;
        if ({d, digit3, digit2, digit1, digit0} !== {8'hEE, 16'h1234})
            $display("FAIL all_bad_keep got tx=%h dig=%h want EE 1234", d, {digit3, digit2, digit1, digit0});
        else pass_cnt++;
    endtask

    task automatic test_read;
        logic r; logic [7:0] d;
        send(8'h40, r, d);
        total_cnt++;
        if ({r, d} !== {1'b1, 8'h12}) $display("FAIL read_hi got rdy=%b tx=%h want 1 12", r, d);
        else pass_cnt++;
        send(8'h00, r, d);
        total_cnt++;
        if ({r, d, busy} !== {1'b1, 8'h34, 1'b0})
            $display("FAIL read_lo got rdy=%b tx=%h busy=%b want 1 34 0", r, d, busy);
        else pass_cnt++;
    endtask

    task automatic test_opcodes;
        logic r; logic [7:0] d;
        send(8'h99, r, d);
        total_cnt++;
        if ({d, err_flag, busy} !== {8'hEE, 1'b1, 1'b0})
            $display("FAIL bad_op got tx=%h err=%b busy=%b want EE 1 0", d, err_flag, busy);
        else pass_cnt++;
        send(8'h50, r, d);
        total_cnt++;
        if ({d, err_flag} !== {8'hA5, 1'b0}) $display("FAIL clr_err got tx=%h err=%b want A5 0", d, err_flag);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h20;
        @(negedge clk);
        rx_data  = 8'h01;
        total_cnt++;
        if ({tx_ready, tx_data} !== {1'b1, 8'hA5}) $display("FAIL b2b_first got rdy=%b tx=%h want 1 A5", tx_ready, tx_data);
        else pass_cnt++;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        total_cnt++;
        if ({tx_ready, tx_data, colon} !== {1'b1, 8'hA5, 2'b01})
            $display("FAIL b2b_second got rdy=%b tx=%h colon=%b want 1 A5 01", tx_ready, tx_data, colon);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({tx_ready, busy} !== 2'b00) $display("FAIL b2b_idle got rdy=%b busy=%b want 0 0", tx_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        logic r; logic [7:0] d;
        int spurious;
        spurious = 0;
        send(8'h10, r, d);
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) spurious++;
        end
        total_cnt++;
        if ({busy, err_flag} !== 2'b10)
            $display("FAIL timeout_before got busy=%b err=%b want 1 0", busy, err_flag);
        else pass_cnt++;
        @(negedge clk);
        if (tx_ready !== 1'b0) spurious++;
        total_cnt++;
        if ({busy, err_flag} !== 2'b01)
            $display("FAIL timeout_expire got busy=%b err=%b want 0 1", busy, err_flag);
        else pass_cnt++;
        total_cnt++;
        if (spurious != 0) $display("FAIL timeout_no_pulse got %0d pulses want 0", spurious);
        else pass_cnt++;
    endtask

    task automatic test_timeout_race;
        logic r; logic [7:0] d;
        send(8'h50, r, d);
        send(8'h10, r, d);
        repeat (18) @(negedge clk);
        // The argument is captured on the edge where the counter sits at its last value.
        send(8'h05, r, d);
        total_cnt++;
        if ({r, d, err_flag, busy} !== {1'b1, 8'hA5, 1'b0, 1'b0})
            $display("FAIL race_reply got rdy=%b tx=%h err=%b busy=%b want 1 A5 0 0", r, d, err_flag, busy);
        else pass_cnt++;
        total_cnt++;
        if ({digit3, digit2, digit1, digit0} !== 16'h1235)
            $display("FAIL race_digit got %h want 1235", {digit3, digit2, digit1, digit0});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_reset_mid();
        test_digit();
        test_all();
        test_all_bad();
        test_read();
        test_opcodes();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
